multicycle_ctrl_fsm: RTL

- Control unit for the multicycle variant of the processor. It drives the control-input side of the conditional-write logic: PCS, RegW, MemW, FlagW, NoWrite.
- Decodes Op/Funct/Rd from the latched instruction. Sequences FETCH/DECODE/EXECUTE/writeback over 3-5 cycles per instruction.
- Drives datapath mux selects, ALUControl and IRWrite/NextPC.
- The conditional-write block gates PCS/RegW/MemW/FlagW with CondEx. PCWrite = (PCS & CondEx) | NextPC is formed outside this block.

---
 rtl/multicycle_ctrl_fsm.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor control unit: FETCH/DECODE/EXECUTE/writeback sequencer with ALU and flag decode.
// Optional CTRL_MEM_WAIT_EN adds a MemReady input that stalls FETCH, MEMRD and MEMWR.
module multicycle_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
`ifdef CTRL_MEM_WAIT_EN
    input  logic       MemReady,
`endif
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic       NextPC,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       InstrDone
);

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       nowrite_q;
    logic       mem_ready;
    logic [1:0] dec_alu;
    logic [1:0] dec_flag;
    logic       dec_nw;
    logic       illegal;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            nowrite_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == EXECR || state == EXECI) begin
                nowrite_q <= dec_nw;
            end
        end
    end

    // Data-processing decode on Funct[4:1]; only consumed in EXECR/EXECI.
    always_comb begin
        dec_alu  = 2'b00;
        dec_nw   = 1'b0;
        dec_flag = {Funct[0], 1'b0};
        case (Funct[4:1])
            4'b0100: dec_flag = {Funct[0], Funct[0]};
            4'b0010: begin
                dec_alu  = 2'b01;
                dec_flag = {Funct[0], Funct[0]};
            end
            4'b0000: dec_alu = 2'b10;
            4'b1100: dec_alu = 2'b11;
            4'b1010: begin
                dec_alu  = 2'b01;
                dec_nw   = 1'b1;
                dec_flag = 2'b11;
            end
            default: begin
                dec_alu  = 2'b00;
                dec_nw   = 1'b1;
                dec_flag = 2'b00;
            end
        endcase
    end

    always_comb begin
        state_nxt  = FETCH;
        illegal    = 1'b0;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        NextPC     = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        InstrDone  = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    state_nxt = DECODE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_nxt = MEMADR;
                    2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_nxt = BRANCH;
                    default: begin
                        state_nxt = FETCH;
                        InstrDone = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB   = 2'b01;
                state_nxt = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
                state_nxt = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                PCS       = (Rd == 4'hF);
                InstrDone = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    MemW      = 1'b1;
                    InstrDone = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = MEMWR;
                end
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = dec_alu;
                FlagW      = dec_flag;
                NoWrite    = dec_nw;
                state_nxt  = ALUWB;
            end
            ALUWB: begin
                RegW      = 1'b1;
                NoWrite   = nowrite_q;
                PCS       = (Rd == 4'hF);
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCS       = 1'b1;
                InstrDone = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (!illegal) begin
            ImmSrc = Op;
            RegSrc = {Op == 2'b01, Op == 2'b10};
        end
        // Outputs stay quiet for the whole reset cycle regardless of the current state.
        if (reset) begin
            PCS        = 1'b0;
            RegW       = 1'b0;
            MemW       = 1'b0;
            FlagW      = 2'b00;
            NoWrite    = 1'b0;
            NextPC     = 1'b0;
            IRWrite    = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ALUControl = 2'b00;
            ImmSrc     = 2'b00;
            RegSrc     = 2'b00;
            InstrDone  = 1'b0;
        end
    end

endmodule
